// File: rtl/aurora_6466b_link_supervisor_if.sv
// =============================================================================
// aurora_6466b_link_supervisor_if: control/status bundle between board logic, Aurora core and supervisor. Rev 1.0
// =============================================================================
`default_nettype none

interface aurora_6466b_link_supervisor_if #(
  parameter int MAX_RETRY = 3
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic          link_en;
  logic          force_retrain;
  logic          channel_up;
  logic          hard_err;
  logic          soft_err;
  logic          pma_init;
  logic          reset_pb;
  logic          link_ok;
  logic          link_fail;
  logic [RW-1:0] retry_cnt;
  logic [2:0]    state_o;

  // master = supervisor side, slave = board/core side
  modport master (
    input  link_en, force_retrain, channel_up, hard_err, soft_err,
    output pma_init, reset_pb, link_ok, link_fail, retry_cnt, state_o
  );

  modport slave (
    output link_en, force_retrain, channel_up, hard_err, soft_err,
    input  pma_init, reset_pb, link_ok, link_fail, retry_cnt, state_o
  );
endinterface

`default_nettype wire

// File: rtl/aurora_6466b_link_supervisor.sv
// =============================================================================
// aurora_6466b_link_supervisor: reset, bring-up and retrain sequencer for one Aurora 64B/66B link. Rev 1.0
// =============================================================================
`default_nettype none

module aurora_6466b_link_supervisor #(
  parameter int PMA_HOLD   = 4096,
  parameter int PB_HOLD    = 512,
  parameter int UP_TIMEOUT = 262144,
  parameter int ERR_WIN    = 1024,
  parameter int ERR_LIMIT  = 8,
  parameter int MAX_RETRY  = 3,
  parameter int SIM_ENABLE = 0
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  aurora_6466b_link_supervisor_if.master     lnk
);

  localparam int PMA_EFF = (SIM_ENABLE != 0) ? 64  : PMA_HOLD;
  localparam int PB_EFF  = (SIM_ENABLE != 0) ? 16  : PB_HOLD;
  localparam int UP_EFF  = (SIM_ENABLE != 0) ? 256 : UP_TIMEOUT;
  localparam int TMAX_A  = (PMA_EFF > PB_EFF) ? PMA_EFF : PB_EFF;
  localparam int TMAX    = (TMAX_A > UP_EFF) ? TMAX_A : UP_EFF;
  localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int WW      = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam int EW      = $clog2(ERR_LIMIT + 1);
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_PMA = 3'd1,
    RST_PB  = 3'd2,
    WAIT_UP = 3'd3,
    LINK_UP = 3'd4,
    FAIL    = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [WW-1:0] win, win_nxt;
  logic [EW-1:0] err, err_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic          fail_evt;
  logic          win_wrap;
  logic [EW-1:0] err_sum;

  // A soft error seen on the wrap cycle seeds the new window rather than the old one.
  assign win_wrap = (win == WW'(ERR_WIN - 1));
  assign err_sum  = win_wrap                 ? EW'(lnk.soft_err) :
                    (err == EW'(ERR_LIMIT))  ? err               :
                                               err + EW'(lnk.soft_err);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    win_nxt   = win;
    err_nxt   = err;
    retry_nxt = retry;
    fail_evt  = 1'b0;

    if (lnk.force_retrain) begin
      retry_nxt = '0;
      timer_nxt = '0;
      win_nxt   = '0;
      err_nxt   = '0;
      state_nxt = lnk.link_en ? RST_PMA : IDLE;
    end else if (!lnk.link_en && state != FAIL) begin
      timer_nxt = '0;
      win_nxt   = '0;
      err_nxt   = '0;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          timer_nxt = '0;
          state_nxt = RST_PMA;
        end
        RST_PMA: begin
          if (timer == TW'(PMA_EFF - 1)) begin
            timer_nxt = '0;
            state_nxt = RST_PB;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
        RST_PB: begin
          if (timer == TW'(PB_EFF - 1)) begin
            timer_nxt = '0;
            state_nxt = WAIT_UP;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
        WAIT_UP: begin
          if (lnk.channel_up) begin
            timer_nxt = '0;
            win_nxt   = '0;
            err_nxt   = '0;
            retry_nxt = '0;
            state_nxt = LINK_UP;
          end else if (timer == TW'(UP_EFF - 1)) begin
            fail_evt = 1'b1;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
        LINK_UP: begin
          if (!lnk.channel_up || lnk.hard_err || (err_sum >= EW'(ERR_LIMIT))) begin
            fail_evt = 1'b1;
          end else begin
            win_nxt = win_wrap ? '0 : win + WW'(1);
            err_nxt = err_sum;
          end
        end
        FAIL: begin
          state_nxt = FAIL;
        end
        default: begin
          timer_nxt = '0;
          state_nxt = IDLE;
        end
      endcase

      if (fail_evt) begin
        timer_nxt = '0;
        win_nxt   = '0;
        err_nxt   = '0;
        if (retry < RW'(MAX_RETRY)) begin
          retry_nxt = retry + RW'(1);
          state_nxt = RST_PMA;
        end else begin
          state_nxt = FAIL;
        end
      end
    end
  end

  // Outputs decode the next state so they move on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      win           <= '0;
      err           <= '0;
      retry         <= '0;
      lnk.pma_init  <= 1'b1;
      lnk.reset_pb  <= 1'b1;
      lnk.link_ok   <= 1'b0;
      lnk.link_fail <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      win           <= win_nxt;
      err           <= err_nxt;
      retry         <= retry_nxt;
      lnk.pma_init  <= (state_nxt == IDLE) || (state_nxt == RST_PMA) || (state_nxt == FAIL);
      lnk.reset_pb  <= (state_nxt == IDLE) || (state_nxt == RST_PMA) ||
                       (state_nxt == RST_PB) || (state_nxt == FAIL);
      lnk.link_ok   <= (state_nxt == LINK_UP);
      lnk.link_fail <= (state_nxt == FAIL);
    end
  end

  assign lnk.retry_cnt = retry;
  assign lnk.state_o   = state;

endmodule

`default_nettype wire
